// File: rtl/imem_loader.sv
// imem_loader: programs the instruction memory from a byte stream.
// Stream: 16-bit little-endian word count N, then 4*N bytes (words little-endian).
// The CPU is held in reset for the whole load so fetch never sees a partial image.
//
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   start             1-cycle pulse, begins a load from IDLE or ERR
//   byte_valid/data   incoming stream byte
//   byte_ready        loader accepts the byte this cycle (xfer = valid & ready)
//   imem_we/waddr/wdata  instruction memory write port, one strobe per word
//   cpu_hold          keep CPU in reset while high
//   busy              load in progress (HDR0..WRITE)
//   done              1-cycle pulse after the final word is written
//   error             sticky bad-length flag, cleared by the next accepted start
module imem_loader #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  state_t            state;
  logic [7:0]        n_lo;
  logic [15:0]       word_cnt;
  logic [IDX_W-1:0]  word_idx;
  logic [1:0]        byte_cnt;
  logic [23:0]       asm_word;   // lanes 0..2; lane 3 goes straight to imem_wdata
  logic              xfer;
  logic [15:0]       n_hdr;

  assign xfer  = byte_valid & byte_ready;
  assign n_hdr = {byte_data, n_lo};

  // FSM with registered outputs; every output is updated together with the state
  // it belongs to, so the outputs always match the current state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      n_lo       <= 8'd0;
      word_cnt   <= 16'd0;
      word_idx   <= '0;
      byte_cnt   <= 2'd0;
      asm_word   <= 24'd0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= 32'd0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE, ERR: begin
          if (start) begin
            state      <= HDR0;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            cpu_hold   <= 1'b1;
            error      <= 1'b0;
            byte_cnt   <= 2'd0;
            word_idx   <= '0;
            asm_word   <= 24'd0;
          end
        end

        HDR0: begin
          if (xfer) begin
            n_lo  <= byte_data;
            state <= HDR1;
          end
        end

        HDR1: begin
          if (xfer) begin
            if ((n_hdr == 16'd0) || (n_hdr > DEPTH16)) begin
              state      <= ERR;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              cpu_hold   <= 1'b0;
              error      <= 1'b1;
            end else begin
              word_cnt <= n_hdr;
              state    <= DATA;
            end
          end
        end

        DATA: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: asm_word[7:0]   <= byte_data;
              2'd1: asm_word[15:8]  <= byte_data;
              2'd2: asm_word[23:16] <= byte_data;
              default: begin
                state      <= WRITE;
                byte_ready <= 1'b0;
                imem_we    <= 1'b1;
                imem_waddr <= word_idx[ADDR_W-1:0];
                imem_wdata <= {byte_data, asm_word};
              end
            endcase
          end
        end

        WRITE: begin
          word_idx <= word_idx + IDX_W'(1);
          if (16'(word_idx) == (word_cnt - 16'd1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state      <= DATA;
            byte_ready <= 1'b1;
          end
        end

        DONE: begin
          state    <= IDLE;
          cpu_hold <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          cpu_hold   <= 1'b0;
        end
      endcase
    end
  end

endmodule
